// File: rtl/slink_app_chk_pkg.sv
// Shared definitions for the S-Link RX application checker: error bit
// indices, flag vector width and the framing state encoding.
package slink_app_chk_pkg;

    localparam int ERR_SOP_NO_VALID  = 0;
    localparam int ERR_EARLY_SOP     = 1;
    localparam int ERR_ORPHAN_BEAT   = 2;
    localparam int ERR_CRC_MISPLACED = 3;
    localparam int ERR_GAP_TIMEOUT   = 4;
    localparam int ERR_CRC_BAD       = 5;
    localparam int ERR_W             = 6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LONG = 1'b1
    } state_e;

endpackage

// File: rtl/slink_app_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module slink_app_sat_counter
    import slink_app_chk_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {W{1'b0}};
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/slink_app_rx_checker.sv
// Synthesizable framing/XOR checker for the S-Link RX application port.
// Statistics counters are built only when SLINK_APP_RX_CHECKER_STATS_EN is defined.
module slink_app_rx_checker
    import slink_app_chk_pkg::*;
#(
    parameter int          APP_DATA_WIDTH = 32,
    parameter logic [7:0]  SHORT_ID_MAX   = 8'h1f,
    parameter int          GAP_TIMEOUT    = 16,
    parameter int          CNT_WIDTH      = 16
) (
    input  logic                      link_clk,
    input  logic                      link_reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic                      rx_sop,
    input  logic                      rx_valid,
    input  logic                      rx_crc_corrupted,
    input  logic [7:0]                rx_data_id,
    input  logic [15:0]               rx_word_count,
    input  logic [APP_DATA_WIDTH-1:0] rx_app_data,
    output logic                      busy,
    output logic [ERR_W-1:0]          err_flags,
    output logic                      err_pulse,
    output logic                      pkt_done,
    output logic [7:0]                pkt_id,
    output logic [15:0]               pkt_wc,
    output logic [7:0]                pkt_xor,
    output logic                      pkt_crc_bad,
    output logic [CNT_WIDTH-1:0]      cnt_short,
    output logic [CNT_WIDTH-1:0]      cnt_long,
    output logic [CNT_WIDTH-1:0]      cnt_err,
    output logic [CNT_WIDTH-1:0]      cnt_crc
);

    localparam int          BYTES    = APP_DATA_WIDTH / 8;
    localparam logic [15:0] BYTES16  = 16'(BYTES);
    localparam int          GAP_W    = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TIMEOUT > 0) ? (GAP_TIMEOUT - 1) : 0);

    function automatic logic [15:0] min_take(input logic [15:0] n);
        logic [15:0] t;
        if (n < BYTES16) begin
            t = n;
        end else begin
            t = BYTES16;
        end
        return t;
    endfunction

    // XOR of byte lanes 0..take-1; higher lanes never contribute.
    function automatic logic [7:0] lane_xor(input logic [APP_DATA_WIDTH-1:0] data,
                                            input logic [15:0] take);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < BYTES; i++) begin
            if (16'(i) < take) begin
                acc = acc ^ data[i*8 +: 8];
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    state_e             state_q, state_d;
    logic [15:0]        rem_q, rem_d;
    logic [7:0]         xor_q, xor_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         id_q, id_d;
    logic [15:0]        wc_q, wc_d;
    logic               busy_q, busy_d;
    logic [ERR_W-1:0]   err_flags_q, err_flags_d;
    logic               err_pulse_q, err_pulse_d;
    logic               pkt_done_q, pkt_done_d;
    logic [7:0]         pkt_id_q, pkt_id_d;
    logic [15:0]        pkt_wc_q, pkt_wc_d;
    logic [7:0]         pkt_xor_q, pkt_xor_d;
    logic               pkt_crc_bad_q, pkt_crc_bad_d;

    logic               beat_s;
    logic               short_done_s;
    logic               long_done_s;
    logic [ERR_W-1:0]   flags_set_s;
    logic [ERR_W-1:0]   newly_s;
    logic [15:0]        take_s;
    logic [7:0]         lanes_s;
    logic [15:0]        rem_new_s;

    assign beat_s = enable && rx_valid;

    // Framing state machine, error detection and completed-packet summary.
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        xor_d         = xor_q;
        gap_d         = gap_q;
        id_d          = id_q;
        wc_d          = wc_q;
        pkt_id_d      = pkt_id_q;
        pkt_wc_d      = pkt_wc_q;
        pkt_xor_d     = pkt_xor_q;
        pkt_crc_bad_d = pkt_crc_bad_q;
        short_done_s  = 1'b0;
        long_done_s   = 1'b0;
        flags_set_s   = {ERR_W{1'b0}};
        take_s        = 16'h0000;
        lanes_s       = 8'h00;
        rem_new_s     = 16'h0000;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            if (rx_sop && !rx_valid) begin
                flags_set_s[ERR_SOP_NO_VALID] = 1'b1;
            end else begin
                flags_set_s[ERR_SOP_NO_VALID] = 1'b0;
            end

            if (beat_s) begin
                gap_d = {GAP_W{1'b0}};
                if (rx_sop) begin
                    if (state_q == ST_LONG) begin
                        flags_set_s[ERR_EARLY_SOP] = 1'b1;
                    end else begin
                        flags_set_s[ERR_EARLY_SOP] = 1'b0;
                    end
                    if (rx_data_id <= SHORT_ID_MAX) begin
                        state_d                         = ST_IDLE;
                        short_done_s                    = 1'b1;
                        pkt_id_d                        = rx_data_id;
                        pkt_wc_d                        = rx_word_count;
                        pkt_xor_d                       = 8'h00;
                        pkt_crc_bad_d                   = 1'b0;
                        flags_set_s[ERR_CRC_MISPLACED]  = rx_crc_corrupted;
                    end else begin
                        take_s    = min_take(rx_word_count);
                        lanes_s   = lane_xor(rx_app_data, take_s);
                        rem_new_s = rx_word_count - take_s;
                        if (rem_new_s == 16'h0000) begin
                            state_d                   = ST_IDLE;
                            long_done_s               = 1'b1;
                            pkt_id_d                  = rx_data_id;
                            pkt_wc_d                  = rx_word_count;
                            pkt_xor_d                 = lanes_s;
                            pkt_crc_bad_d             = rx_crc_corrupted;
                            flags_set_s[ERR_CRC_BAD]  = rx_crc_corrupted;
                        end else begin
                            state_d                         = ST_LONG;
                            rem_d                           = rem_new_s;
                            xor_d                           = lanes_s;
                            id_d                            = rx_data_id;
                            wc_d                            = rx_word_count;
                            flags_set_s[ERR_CRC_MISPLACED]  = rx_crc_corrupted;
                        end
                    end
                end else if (state_q == ST_LONG) begin
                    take_s    = min_take(rem_q);
                    lanes_s   = lane_xor(rx_app_data, take_s);
                    rem_new_s = rem_q - take_s;
                    rem_d     = rem_new_s;
                    xor_d     = xor_q ^ lanes_s;
                    if (rem_new_s == 16'h0000) begin
                        state_d                   = ST_IDLE;
                        long_done_s               = 1'b1;
                        pkt_id_d                  = id_q;
                        pkt_wc_d                  = wc_q;
                        pkt_xor_d                 = xor_q ^ lanes_s;
                        pkt_crc_bad_d             = rx_crc_corrupted;
                        flags_set_s[ERR_CRC_BAD]  = rx_crc_corrupted;
                    end else begin
                        flags_set_s[ERR_CRC_MISPLACED] = rx_crc_corrupted;
                    end
                end else begin
                    flags_set_s[ERR_ORPHAN_BEAT]   = 1'b1;
                    flags_set_s[ERR_CRC_MISPLACED] = rx_crc_corrupted;
                end
            end else if ((state_q == ST_LONG) && (GAP_TIMEOUT != 0)) begin
                if (gap_q == GAP_LAST) begin
                    state_d                      = ST_IDLE;
                    gap_d                        = {GAP_W{1'b0}};
                    flags_set_s[ERR_GAP_TIMEOUT] = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end else begin
                gap_d = gap_q;
            end
        end

        pkt_done_d = short_done_s || long_done_s;
        busy_d     = (state_d == ST_LONG);
    end

    // Sticky flags and the newly-set pulse; clear overrides same-cycle sets.
    always_comb begin
        newly_s = flags_set_s & ~err_flags_q;
        if (clear) begin
            err_flags_d = {ERR_W{1'b0}};
            err_pulse_d = 1'b0;
        end else begin
            err_flags_d = err_flags_q | flags_set_s;
            err_pulse_d = |newly_s;
        end
    end

    // State and output registers.
    always_ff @(posedge link_clk) begin
        if (link_reset) begin
            state_q       <= ST_IDLE;
            rem_q         <= 16'h0000;
            xor_q         <= 8'h00;
            gap_q         <= {GAP_W{1'b0}};
            id_q          <= 8'h00;
            wc_q          <= 16'h0000;
            busy_q        <= 1'b0;
            err_flags_q   <= {ERR_W{1'b0}};
            err_pulse_q   <= 1'b0;
            pkt_done_q    <= 1'b0;
            pkt_id_q      <= 8'h00;
            pkt_wc_q      <= 16'h0000;
            pkt_xor_q     <= 8'h00;
            pkt_crc_bad_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            xor_q         <= xor_d;
            gap_q         <= gap_d;
            id_q          <= id_d;
            wc_q          <= wc_d;
            busy_q        <= busy_d;
            err_flags_q   <= err_flags_d;
            err_pulse_q   <= err_pulse_d;
            pkt_done_q    <= pkt_done_d;
            pkt_id_q      <= pkt_id_d;
            pkt_wc_q      <= pkt_wc_d;
            pkt_xor_q     <= pkt_xor_d;
            pkt_crc_bad_q <= pkt_crc_bad_d;
        end
    end

    assign busy        = busy_q;
    assign err_flags   = err_flags_q;
    assign err_pulse   = err_pulse_q;
    assign pkt_done    = pkt_done_q;
    assign pkt_id      = pkt_id_q;
    assign pkt_wc      = pkt_wc_q;
    assign pkt_xor     = pkt_xor_q;
    assign pkt_crc_bad = pkt_crc_bad_q;

`ifdef SLINK_APP_RX_CHECKER_STATS_EN
    slink_app_sat_counter #(.W(CNT_WIDTH)) u_cnt_short (
        .clk(link_clk), .rst(link_reset), .clear(clear), .inc(short_done_s), .count(cnt_short)
    );
    slink_app_sat_counter #(.W(CNT_WIDTH)) u_cnt_long (
        .clk(link_clk), .rst(link_reset), .clear(clear), .inc(long_done_s), .count(cnt_long)
    );
    slink_app_sat_counter #(.W(CNT_WIDTH)) u_cnt_err (
        .clk(link_clk), .rst(link_reset), .clear(clear), .inc(err_pulse_d), .count(cnt_err)
    );
    slink_app_sat_counter #(.W(CNT_WIDTH)) u_cnt_crc (
        .clk(link_clk), .rst(link_reset), .clear(clear), .inc(flags_set_s[ERR_CRC_BAD]), .count(cnt_crc)
    );
`else
    assign cnt_short = {CNT_WIDTH{1'b0}};
    assign cnt_long  = {CNT_WIDTH{1'b0}};
    assign cnt_err   = {CNT_WIDTH{1'b0}};
    assign cnt_crc   = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_slink_app_rx_checker.sv
// Scoreboard bench for slink_app_rx_checker (GAP_TIMEOUT=4, CNT_WIDTH=2);
// counter expectations follow SLINK_APP_RX_CHECKER_STATS_EN.
module tb_slink_app_rx_checker;

    logic        link_clk = 1'b0;
    logic        link_reset;
    logic        enable;
    logic        clear;
    logic        rx_sop;
    logic        rx_valid;
    logic        rx_crc_corrupted;
    logic [7:0]  rx_data_id;
    logic [15:0] rx_word_count;
    logic [31:0] rx_app_data;
    logic        busy;
    logic [5:0]  err_flags;
    logic        err_pulse;
    logic        pkt_done;
    logic [7:0]  pkt_id;
    logic [15:0] pkt_wc;
    logic [7:0]  pkt_xor;
    logic        pkt_crc_bad;
    logic [1:0]  cnt_short, cnt_long, cnt_err, cnt_crc;

    typedef struct {
        logic [7:0]  id;
        logic [15:0] wc;
        logic [7:0]  x;
        logic        crc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pulses = 0;

    slink_app_rx_checker #(
        .APP_DATA_WIDTH(32), .SHORT_ID_MAX(8'h1f), .GAP_TIMEOUT(4), .CNT_WIDTH(2)
    ) dut (
        .link_clk(link_clk), .link_reset(link_reset), .enable(enable), .clear(clear),
        .rx_sop(rx_sop), .rx_valid(rx_valid), .rx_crc_corrupted(rx_crc_corrupted),
        .rx_data_id(rx_data_id), .rx_word_count(rx_word_count), .rx_app_data(rx_app_data),
        .busy(busy), .err_flags(err_flags), .err_pulse(err_pulse), .pkt_done(pkt_done),
        .pkt_id(pkt_id), .pkt_wc(pkt_wc), .pkt_xor(pkt_xor), .pkt_crc_bad(pkt_crc_bad),
        .cnt_short(cnt_short), .cnt_long(cnt_long), .cnt_err(cnt_err), .cnt_crc(cnt_crc)
    );

    always #5 link_clk = ~link_clk;

    function automatic logic [31:0] ecnt(input int v);
`ifdef SLINK_APP_RX_CHECKER_STATS_EN
        return 32'(v);
`else
        return 32'(v - v);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_pkt(input logic [7:0] id, input logic [15:0] wc,
                              input logic [7:0] x, input logic crc);
        exp_t e;
        e.id = id; e.wc = wc; e.x = x; e.crc = crc;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic sop, input logic valid, input logic [7:0] id,
                         input logic [15:0] wc, input logic [31:0] data, input logic crc);
        rx_sop = sop; rx_valid = valid; rx_data_id = id;
        rx_word_count = wc; rx_app_data = data; rx_crc_corrupted = crc;
        @(posedge link_clk); #1;
        rx_sop = 1'b0; rx_valid = 1'b0; rx_crc_corrupted = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge link_clk); #1;
        end
    endtask

    // Monitor: pop and compare a summary whenever the DUT reports a packet.
    always @(negedge link_clk) begin
        if (!link_reset) begin
            if (err_pulse) n_pulses++;
            if (pkt_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pkt_done", {24'h0, pkt_id}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pkt_id", {24'h0, pkt_id}, {24'h0, e.id});
                    check("pkt_wc", {16'h0, pkt_wc}, {16'h0, e.wc});
                    check("pkt_xor", {24'h0, pkt_xor}, {24'h0, e.x});
                    check("pkt_crc_bad", {31'h0, pkt_crc_bad}, {31'h0, e.crc});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        link_reset = 1'b1; enable = 1'b1; clear = 1'b0;
        rx_sop = 1'b0; rx_valid = 1'b0; rx_crc_corrupted = 1'b0;
        rx_data_id = 8'h00; rx_word_count = 16'h0000; rx_app_data = 32'h0;
        idle(3);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err_flags", {26'h0, err_flags}, 32'h0);
        check("rst_err_pulse", {31'h0, err_pulse}, 32'h0);
        check("rst_pkt_done", {31'h0, pkt_done}, 32'h0);
        check("rst_pkt_summary", {pkt_id, pkt_wc, pkt_xor}, 32'h0);
        check("rst_pkt_crc_bad", {31'h0, pkt_crc_bad}, 32'h0);
        check("rst_counters", {24'h0, cnt_short, cnt_long, cnt_err, cnt_crc}, 32'h0);
        link_reset = 1'b0;
        idle(1);

        // Short packet.
        expect_pkt(8'h05, 16'h1234, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 8'h05, 16'h1234, 32'hDEADBEEF, 1'b0);
        check("short_err_flags", {26'h0, err_flags}, 32'h0);
        check("short_cnt_short", {30'h0, cnt_short}, ecnt(1));

        // Long packet over three beats, top lanes of the last beat ignored.
        expect_pkt(8'h22, 16'd10, 8'h0B, 1'b0);
        drive(1'b1, 1'b1, 8'h22, 16'd10, 32'h04030201, 1'b0);
        check("long_busy_mid", {31'h0, busy}, 32'h1);
        drive(1'b0, 1'b1, 8'h00, 16'd0, 32'h08070605, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 16'd0, 32'hFFFF0A09, 1'b0);
        check("long_busy_end", {31'h0, busy}, 32'h0);
        check("long_cnt_long", {30'h0, cnt_long}, ecnt(1));

        // Long packet with zero word count completes on the SOP beat.
        expect_pkt(8'h30, 16'd0, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 8'h30, 16'd0, 32'h12345678, 1'b0);
        check("wc0_busy", {31'h0, busy}, 32'h0);

        // Early SOP aborts the first packet; the second completes.
        drive(1'b1, 1'b1, 8'h22, 16'd12, 32'h11111111, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 16'd0, 32'h22222222, 1'b0);
        expect_pkt(8'h23, 16'd4, 8'h44, 1'b0);
        drive(1'b1, 1'b1, 8'h23, 16'd4, 32'h44332211, 1'b0);
        idle(1);
        check("early_sop_flags", {26'h0, err_flags}, 32'h02);
        check("early_sop_pulses", n_pulses, 32'd1);

        // Gap timeout after four idle cycles, then an orphan beat.
        drive(1'b1, 1'b1, 8'h24, 16'd8, 32'h01010101, 1'b0);
        idle(4);
        check("gap_flag", {31'h0, err_flags[4]}, 32'h1);
        check("gap_busy", {31'h0, busy}, 32'h0);
        drive(1'b0, 1'b1, 8'h00, 16'd0, 32'h02020202, 1'b0);
        check("orphan_flags", {26'h0, err_flags}, 32'h16);

        // CRC on a non-final beat, then CRC on a final beat.
        expect_pkt(8'h25, 16'd12, 8'h07, 1'b0);
        drive(1'b1, 1'b1, 8'h25, 16'd12, 32'h00000001, 1'b1);
        drive(1'b0, 1'b1, 8'h00, 16'd0, 32'h00000002, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 16'd0, 32'h00000004, 1'b0);
        check("crc_misplaced_flags", {26'h0, err_flags}, 32'h1E);
        expect_pkt(8'h26, 16'd8, 8'hFF, 1'b1);
        drive(1'b1, 1'b1, 8'h26, 16'd8, 32'h000000F0, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 16'd0, 32'h0000000F, 1'b1);
        idle(1);
        check("crc_bad_flags", {26'h0, err_flags}, 32'h3E);
        check("crc_cnt_crc", {30'h0, cnt_crc}, ecnt(1));
        check("sat_cnt_long", {30'h0, cnt_long}, ecnt(3));
        check("sat_cnt_err", {30'h0, cnt_err}, ecnt(3));
        check("pulses_before_clear", n_pulses, 32'd5);

        // Clear wipes flags and counters.
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        check("clear_flags", {26'h0, err_flags}, 32'h0);
        check("clear_counters", {24'h0, cnt_short, cnt_long, cnt_err, cnt_crc}, 32'h0);

        // Five short packets saturate a 2-bit counter at 3.
        for (int i = 1; i <= 5; i++) begin
            expect_pkt(8'(i), 16'(i), 8'h00, 1'b0);
            drive(1'b1, 1'b1, 8'(i), 16'(i), 32'hA5A5A5A5, 1'b0);
        end
        check("sat_cnt_short", {30'h0, cnt_short}, ecnt(3));

        // SOP without valid.
        drive(1'b1, 1'b0, 8'h40, 16'd8, 32'h0, 1'b0);
        check("sop_no_valid_flags", {26'h0, err_flags}, 32'h01);

        // Disable drops the packet silently; the following beat is an orphan.
        drive(1'b1, 1'b1, 8'h27, 16'd8, 32'h01020304, 1'b0);
        check("en_busy_before", {31'h0, busy}, 32'h1);
        enable = 1'b0;
        drive(1'b0, 1'b1, 8'h00, 16'd0, 32'h05060708, 1'b0);
        check("en_low_busy", {31'h0, busy}, 32'h0);
        check("en_low_flags", {26'h0, err_flags}, 32'h01);
        enable = 1'b1;
        drive(1'b0, 1'b1, 8'h00, 16'd0, 32'h05060708, 1'b0);
        check("en_orphan_flags", {26'h0, err_flags}, 32'h05);

        // CRC on a short packet is misplaced.
        expect_pkt(8'h02, 16'd0, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 8'h02, 16'd0, 32'h0, 1'b1);
        check("short_crc_flags", {26'h0, err_flags}, 32'h0D);

        // Clear wins over a same-cycle flag set.
        clear = 1'b1;
        drive(1'b1, 1'b0, 8'h41, 16'd0, 32'h0, 1'b0);
        clear = 1'b0;
        check("clear_prio_flags", {26'h0, err_flags}, 32'h0);
        check("clear_prio_pulse", {31'h0, err_pulse}, 32'h0);
        check("clear_prio_cnt_err", {30'h0, cnt_err}, 32'h0);

        // Reset mid-packet: no completion, back to idle.
        drive(1'b1, 1'b1, 8'h28, 16'd8, 32'h0, 1'b0);
        link_reset = 1'b1;
        idle(1);
        link_reset = 1'b0;
        check("midrst_busy", {31'h0, busy}, 32'h0);
        drive(1'b0, 1'b1, 8'h00, 16'd0, 32'h0, 1'b0);
        check("midrst_orphan_flags", {26'h0, err_flags}, 32'h04);
        idle(3);

        check("pulse_total", n_pulses, 32'd9);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
